inst_mem_loader: RTL
====================

Name: inst_mem_loader

Overview:
- Write-side counterpart of the byte-addressed instruction memory, which is read-only during fetch.
- Accepts 32-bit instruction words over a valid/ready stream and writes each word as 4 byte writes, little-endian: bits 7:0 go to the lowest address.
- Writes start at a word-aligned base address and stop on request or when memory is full.
- Sits between the program-load source (testbench or boot stream) and the instruction memory's write port, before the core is released to fetch.

Parameters:
- MEM_BYTES, 16, instruction memory size in bytes; must be a multiple of 4 and at least 4.
- CNT_W, 16, width of Words_Loaded.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Load_Start  input  1  one-cycle pulse; begins a load session at Base_Address
- Base_Address  input  64  first byte address of the session; sampled on Load_Start
- Load_End  input  1  one-cycle pulse; ends the session after any in-flight word
- Word_In  input  32  instruction word
- Word_Valid  input  1  Word_In is valid
- Word_Ready  output  1  loader accepts Word_In this cycle
- Mem_Write_En  output  1  byte write strobe to the instruction memory
- Mem_Write_Address  output  64  byte address of the write
- Mem_Write_Data  output  8  byte to write
- Load_Busy  output  1  a session is active
- Load_Done  output  1  one-cycle pulse when a session completes
- Overflow_Error  output  1  sticky; Base_Address was rejected
- Words_Loaded  output  CNT_W  number of words fully written in the current or last session

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All outputs 0: Word_Ready, Mem_Write_En, Mem_Write_Address, Mem_Write_Data, Load_Busy, Load_Done, Overflow_Error, Words_Loaded.
  - Internal pointer, byte index, word latch and end-pending flag cleared.
  - Reset mid-word aborts the word: bytes already written stay in memory, no further writes, no Load_Done.
- Outputs are driven only from registers. There is no combinational input-to-output path; Word_Ready depends on state only.
- IDLE:
  - Word_Ready = 0, Load_Busy = 0.
  - On Load_Start, check Base_Address:
    - Bad if Base_Address[1:0] != 0 or Base_Address > MEM_BYTES-4. Then set Overflow_Error = 1 and stay in IDLE.
    - Otherwise: ptr <= Base_Address, Words_Loaded <= 0, Overflow_Error <= 0, go to ACCEPT.
  - Load_End in IDLE is ignored.
- ACCEPT:
  - Word_Ready = 1, Load_Busy = 1.
  - Handshake at a rising edge with Word_Valid & Word_Ready: latch Word_In, byte index idx <= 0, go to WRITE.
  - Load_End with no handshake: go to DONE.
  - Load_End and handshake in the same cycle: accept the word, set end_pending, write the word, then go to DONE.
- WRITE (4 cycles, idx = 0..3):
  - Word_Ready = 0.
  - Mem_Write_En = 1, Mem_Write_Address = ptr + idx, Mem_Write_Data = word[8*idx+7 : 8*idx].
  - Load_End arriving here sets end_pending.
  - After idx = 3:
    - ptr <= ptr + 4, Words_Loaded <= Words_Loaded + 1.
    - If end_pending or ptr + 4 == MEM_BYTES: go to DONE.
    - Otherwise go to ACCEPT.
- DONE:
  - Load_Done = 1 for exactly one cycle, Load_Busy = 1, Word_Ready = 0.
  - Next state is IDLE; end_pending cleared.
- Timing:
  - Handshake at edge N → byte 0 written in cycle N+1, byte 3 in cycle N+4.
  - Next Word_Ready in cycle N+5.
  - Throughput is 1 word per 5 cycles.
- Load_Start while Load_Busy = 1 is ignored.
- Words_Loaded holds its value after DONE until the next accepted Load_Start.
- Mem_Write_Address and Mem_Write_Data hold their last value when Mem_Write_En = 0; do not rely on them then.

Test Plan:
- Reset, Load_Start with Base_Address = 0, send word 0x00A00093 → byte writes 0x93@0, 0x00@1, 0xA0@2, 0x00@3 in 4 consecutive cycles; Words_Loaded = 1, Word_Ready high again 5 cycles after the handshake.
- Base 0, send 4 words back-to-back with Word_Valid held high → 16 byte writes to addresses 0..15; Load_Done pulses once after the 4th word; Words_Loaded = 4; Word_Ready never rises after the last word (memory full).
- Base 8, send 1 word, then Load_End in ACCEPT → writes to 8..11, then Load_Done; Words_Loaded = 1. Separately, Load_End in the same cycle as a handshake → that word is fully written, then Load_Done.
- Load_Start with Base_Address = 6, and separately 16 → Overflow_Error = 1, Load_Busy stays 0, no writes; a following Load_Start at 0 clears Overflow_Error.
- Assert reset after byte 1 of a word → all outputs 0 immediately, no Load_Done, bytes 2..3 never written; a new session then loads normally.
- Load_Start pulsed during WRITE → ignored; ptr and Words_Loaded unaffected.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: takes 32-bit words over valid/ready and writes each one
// as four little-endian byte writes starting at a word-aligned base address.
module inst_mem_loader #(
    parameter int unsigned MEM_BYTES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Load_Start,
    input  logic [63:0]      Base_Address,
    input  logic             Load_End,
    input  logic [31:0]      Word_In,
    input  logic             Word_Valid,
    output logic             Word_Ready,
    output logic             Mem_Write_En,
    output logic [63:0]      Mem_Write_Address,
    output logic [7:0]       Mem_Write_Data,
    output logic             Load_Busy,
    output logic             Load_Done,
    output logic             Overflow_Error,
    output logic [CNT_W-1:0] Words_Loaded
);
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned WORD_W = 32;
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(MEM_BYTES - 4);
    localparam logic [ADDR_W-1:0] MEM_END   = ADDR_W'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]        idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              end_pend_q, end_pend_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovf_d;
    logic [ADDR_W-1:0] next_ptr_c;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [7:0]        wr_data_d;

    // Next-state and next-register values; every output is a flop fed from these.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        word_d     = word_q;
        end_pend_d = end_pend_q;
        cnt_d      = Words_Loaded;
        ovf_d      = Overflow_Error;
        next_ptr_c = ptr_q + ADDR_W'(4);

        unique case (state_q)
            IDLE: begin
                if (Load_Start) begin
                    if ((Base_Address[1:0] != 2'b00) || (Base_Address > LAST_BASE)) begin
                        ovf_d = 1'b1;
                    end else begin
                        ptr_d   = Base_Address;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                if (Word_Valid && Word_Ready) begin
                    word_d     = Word_In;
                    idx_d      = 2'd0;
                    end_pend_d = Load_End;
                    state_d    = WRITE;
                end else if (Load_End) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (Load_End) begin
                    end_pend_d = 1'b1;
                end
                if (idx_q == 2'd3) begin
                    ptr_d   = next_ptr_c;
                    cnt_d   = Words_Loaded + CNT_W'(1);
                    // Memory full ends the session just like a requested end.
                    state_d = (end_pend_d || (next_ptr_c == MEM_END)) ? DONE : ACCEPT;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            DONE: begin
                end_pend_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_en_d   = (state_d == WRITE);
        wr_addr_d = ptr_d + ADDR_W'(idx_d);
        wr_data_d = word_d[{idx_d, 3'b000} +: 8];
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            ptr_q             <= '0;
            idx_q             <= '0;
            word_q            <= '0;
            end_pend_q        <= 1'b0;
            Word_Ready        <= 1'b0;
            Mem_Write_En      <= 1'b0;
            Mem_Write_Address <= '0;
            Mem_Write_Data    <= '0;
            Load_Busy         <= 1'b0;
            Load_Done         <= 1'b0;
            Overflow_Error    <= 1'b0;
            Words_Loaded      <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            idx_q          <= idx_d;
            word_q         <= word_d;
            end_pend_q     <= end_pend_d;
            Word_Ready     <= (state_d == ACCEPT);
            Mem_Write_En   <= wr_en_d;
            Load_Busy      <= (state_d != IDLE);
            Load_Done      <= (state_d == DONE);
            Overflow_Error <= ovf_d;
            Words_Loaded   <= cnt_d;
            if (wr_en_d) begin
                Mem_Write_Address <= wr_addr_d;
                Mem_Write_Data    <= wr_data_d;
            end
        end
    end
endmodule
